// File: rtl/x_scan_ctrl.sv
// x_scan_ctrl: sweeps an 8-bit scan value x from 0 up to 159 in STEP
// increments, using an external comparator (eq_in / grt_in) to detect the
// end of each sweep. PASSES complete sweeps make one scan. An overshoot
// past 159 aborts the scan and raises a sticky err flag.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start; err and wrap_cnt hold their last values
// RUN   | x advances by STEP each cycle, sweeps counted in wrap_cnt
// HOLD  | pause high; every register frozen
// DONE  | one cycle after the last sweep; done pulses, start re-arms
module x_scan_ctrl #(
    parameter int unsigned STEP   = 1,
    parameter int unsigned PASSES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       pause,
    input  logic       eq_in,
    input  logic       grt_in,
    output logic [7:0] x,
    output logic       busy,
    output logic       done,
    output logic [3:0] wrap_cnt,
    output logic       err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HOLD = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [7:0] STEP_W    = 8'(STEP);
    localparam logic [3:0] LAST_PASS = 4'(PASSES - 1);

    state_t state;

    // Scan FSM with all outputs registered alongside the state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            x        <= 8'd0;
            wrap_cnt <= 4'd0;
            err      <= 1'b0;
            done     <= 1'b0;
            busy     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state    <= S_RUN;
                        x        <= 8'd0;
                        wrap_cnt <= 4'd0;
                        err      <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                S_RUN: begin
                    // pause outranks the comparator, overshoot outranks end-of-sweep
                    if (pause) begin
                        state <= S_HOLD;
                    end else if (grt_in) begin
                        state <= S_IDLE;
                        err   <= 1'b1;
                        x     <= 8'd0;
                        busy  <= 1'b0;
                    end else if (eq_in) begin
                        x        <= 8'd0;
                        wrap_cnt <= 4'(wrap_cnt + 4'd1);
                        if (wrap_cnt == LAST_PASS) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end
                    end else begin
                        x <= x + STEP_W;
                    end
                end
                S_HOLD: begin
                    if (!pause) begin
                        state <= S_RUN;
                    end
                end
                S_DONE: begin
                    // DONE lasts exactly one cycle, so done needs no extra clearing here
                    if (start) begin
                        state    <= S_RUN;
                        x        <= 8'd0;
                        wrap_cnt <= 4'd0;
                        err      <= 1'b0;
                        busy     <= 1'b1;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_x_scan_ctrl.sv
// Directed bench for x_scan_ctrl. Three instances share clock and reset:
// a (STEP=1, PASSES=2), b (STEP=2, PASSES=2), c (STEP=1, PASSES=1).
// Each instance has its own comparator model on x.
module tb_x_scan_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    logic       a_start, a_pause, a_eq, a_grt, a_busy, a_done, a_err;
    logic [7:0] a_x;
    logic [3:0] a_wrap;
    logic       b_start, b_pause, b_eq, b_grt, b_busy, b_done, b_err;
    logic [7:0] b_x;
    logic [3:0] b_wrap;
    logic       c_start, c_pause, c_eq, c_grt, c_busy, c_done, c_err;
    logic [7:0] c_x;
    logic [3:0] c_wrap;

    assign a_eq  = (a_x == 8'd159);
    assign a_grt = (a_x >  8'd159);
    assign b_eq  = (b_x == 8'd159);
    assign b_grt = (b_x >  8'd159);
    assign c_eq  = (c_x == 8'd159);
    assign c_grt = (c_x >  8'd159);

    x_scan_ctrl #(.STEP(1), .PASSES(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(a_start), .pause(a_pause),
        .eq_in(a_eq), .grt_in(a_grt), .x(a_x), .busy(a_busy),
        .done(a_done), .wrap_cnt(a_wrap), .err(a_err));

    x_scan_ctrl #(.STEP(2), .PASSES(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(b_start), .pause(b_pause),
        .eq_in(b_eq), .grt_in(b_grt), .x(b_x), .busy(b_busy),
        .done(b_done), .wrap_cnt(b_wrap), .err(b_err));

    x_scan_ctrl #(.STEP(1), .PASSES(1)) dut_c (
        .clk(clk), .rst_n(rst_n), .start(c_start), .pause(c_pause),
        .eq_in(c_eq), .grt_in(c_grt), .x(c_x), .busy(c_busy),
        .done(c_done), .wrap_cnt(c_wrap), .err(c_err));

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        a_start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (a_x !== 8'd0 || a_wrap !== 4'd0 || a_busy !== 1'b0 || a_done !== 1'b0 || a_err !== 1'b0)
                begin errors++; $display("FAIL reset_a cyc%0d: x=%0d wrap=%0d busy=%b done=%b err=%b, want all 0", i, a_x, a_wrap, a_busy, a_done, a_err); end
            checks++;
            if (b_busy !== 1'b0 || b_x !== 8'd0 || c_busy !== 1'b0 || c_x !== 8'd0)
                begin errors++; $display("FAIL reset_bc: b_busy=%b b_x=%0d c_busy=%b c_x=%0d, want 0", b_busy, b_x, c_busy, c_x); end
        end
        a_start = 1'b0;
        rst_n   = 1'b1;
        tick();
        checks++;
        if (a_busy !== 1'b0 || a_x !== 8'd0)
            begin errors++; $display("FAIL reset_release: busy=%b x=%0d, want 0 0", a_busy, a_x); end
    endtask

    task automatic test_sweep();
        logic [7:0] ex;
        logic [3:0] ew;
        logic       eb, ed;
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        checks++;
        if (a_x !== 8'd0 || a_busy !== 1'b1 || a_wrap !== 4'd0 || a_done !== 1'b0)
            begin errors++; $display("FAIL sweep_first_run: x=%0d busy=%b wrap=%0d done=%b, want 0 1 0 0", a_x, a_busy, a_wrap, a_done); end
        for (int i = 1; i <= 322; i++) begin
            tick();
            if (i < 320) begin
                ex = 8'(i % 160); ew = 4'(i / 160); eb = 1'b1; ed = 1'b0;
            end else begin
                ex = 8'd0; ew = 4'd2; eb = 1'b0; ed = (i == 320);
            end
            checks++;
            if (a_x !== ex || a_wrap !== ew || a_busy !== eb || a_done !== ed || a_err !== 1'b0)
                begin errors++; $display("FAIL sweep i=%0d: x=%0d wrap=%0d busy=%b done=%b err=%b, want %0d %0d %b %b 0", i, a_x, a_wrap, a_busy, a_done, a_err, ex, ew, eb, ed); end
        end
    endtask

    task automatic test_pause();
        int done_at;
        done_at = -1;
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        tick_n(50);
        checks++;
        if (a_x !== 8'd50)
            begin errors++; $display("FAIL pause_pre: x=%0d want 50", a_x); end
        a_pause = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (a_x !== 8'd50 || a_busy !== 1'b1)
                begin errors++; $display("FAIL pause_hold cyc%0d: x=%0d busy=%b, want 50 1", i, a_x, a_busy); end
        end
        a_pause = 1'b0;
        tick();
        checks++;
        if (a_x !== 8'd50)
            begin errors++; $display("FAIL pause_release: x=%0d want 50", a_x); end
        tick();
        checks++;
        if (a_x !== 8'd51)
            begin errors++; $display("FAIL pause_resume: x=%0d want 51", a_x); end
        // 57 edges since start so far; without the pause done lands on edge 320, pause adds 6
        for (int i = 58; i <= 400 && done_at < 0; i++) begin
            tick();
            if (a_done === 1'b1) done_at = i;
        end
        checks++;
        if (done_at != 326)
            begin errors++; $display("FAIL pause_total: done at edge %0d want 326", done_at); end
        tick();
    endtask

    task automatic test_eq_pause_and_reset();
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        tick_n(159);
        checks++;
        if (a_x !== 8'd159 || a_wrap !== 4'd0)
            begin errors++; $display("FAIL eqp_pre: x=%0d wrap=%0d want 159 0", a_x, a_wrap); end
        a_pause = 1'b1;
        tick_n(2);
        checks++;
        if (a_x !== 8'd159 || a_wrap !== 4'd0 || a_busy !== 1'b1)
            begin errors++; $display("FAIL eqp_hold: x=%0d wrap=%0d busy=%b want 159 0 1", a_x, a_wrap, a_busy); end
        a_pause = 1'b0;
        tick();
        checks++;
        if (a_x !== 8'd159 || a_wrap !== 4'd0)
            begin errors++; $display("FAIL eqp_release: x=%0d wrap=%0d want 159 0", a_x, a_wrap); end
        tick();
        checks++;
        if (a_x !== 8'd0 || a_wrap !== 4'd1)
            begin errors++; $display("FAIL eqp_wrap: x=%0d wrap=%0d want 0 1", a_x, a_wrap); end
        tick_n(100);
        checks++;
        if (a_x !== 8'd100 || a_wrap !== 4'd1 || a_busy !== 1'b1)
            begin errors++; $display("FAIL rstmid_pre: x=%0d wrap=%0d busy=%b want 100 1 1", a_x, a_wrap, a_busy); end
        rst_n   = 1'b0;
        a_start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (a_x !== 8'd0 || a_wrap !== 4'd0 || a_busy !== 1'b0 || a_done !== 1'b0)
                begin errors++; $display("FAIL rstmid cyc%0d: x=%0d wrap=%0d busy=%b done=%b want 0 0 0 0", i, a_x, a_wrap, a_busy, a_done); end
        end
        a_start = 1'b0;
        rst_n   = 1'b1;
        tick();
        checks++;
        if (a_busy !== 1'b0 || a_x !== 8'd0)
            begin errors++; $display("FAIL rstmid_after: busy=%b x=%0d want 0 0", a_busy, a_x); end
    endtask

    task automatic test_overshoot();
        int done_seen;
        done_seen = 0;
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        for (int k = 1; k <= 80; k++) begin
            tick();
            if (b_done === 1'b1) done_seen++;
        end
        checks++;
        if (b_x !== 8'd160 || b_busy !== 1'b1 || b_err !== 1'b0)
            begin errors++; $display("FAIL over_160: x=%0d busy=%b err=%b want 160 1 0", b_x, b_busy, b_err); end
        tick();
        if (b_done === 1'b1) done_seen++;
        checks++;
        if (b_err !== 1'b1 || b_x !== 8'd0 || b_busy !== 1'b0)
            begin errors++; $display("FAIL over_abort: err=%b x=%0d busy=%b want 1 0 0", b_err, b_x, b_busy); end
        for (int k = 0; k < 5; k++) begin
            tick();
            if (b_done === 1'b1) done_seen++;
        end
        checks++;
        if (b_err !== 1'b1 || b_busy !== 1'b0 || b_x !== 8'd0)
            begin errors++; $display("FAIL over_sticky: err=%b busy=%b x=%0d want 1 0 0", b_err, b_busy, b_x); end
        checks++;
        if (done_seen != 0)
            begin errors++; $display("FAIL over_nodone: done pulses=%0d want 0", done_seen); end
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        checks++;
        if (b_err !== 1'b0 || b_busy !== 1'b1 || b_x !== 8'd0)
            begin errors++; $display("FAIL over_restart: err=%b busy=%b x=%0d want 0 1 0", b_err, b_busy, b_x); end
        tick();
        checks++;
        if (b_x !== 8'd2)
            begin errors++; $display("FAIL over_step: x=%0d want 2", b_x); end
    endtask

    task automatic test_back_to_back();
        logic ed, eb;
        logic [7:0] ex;
        logic [3:0] ew;
        c_start = 1'b1;
        tick();
        checks++;
        if (c_x !== 8'd0 || c_busy !== 1'b1)
            begin errors++; $display("FAIL b2b_first: x=%0d busy=%b want 0 1", c_x, c_busy); end
        for (int i = 1; i <= 330; i++) begin
            tick();
            if (i == 160 || i == 321) begin
                ex = 8'd0; ew = 4'd1; eb = 1'b0; ed = 1'b1;
            end else if (i < 160) begin
                ex = 8'(i); ew = 4'd0; eb = 1'b1; ed = 1'b0;
            end else begin
                ex = 8'((i - 161) % 161); ew = 4'd0; eb = 1'b1; ed = 1'b0;
            end
            checks++;
            if (c_x !== ex || c_wrap !== ew || c_busy !== eb || c_done !== ed)
                begin errors++; $display("FAIL b2b i=%0d: x=%0d wrap=%0d busy=%b done=%b want %0d %0d %b %b", i, c_x, c_wrap, c_busy, c_done, ex, ew, eb, ed); end
        end
        c_start = 1'b0;
    endtask

    initial begin
        rst_n   = 1'b0;
        a_start = 1'b0; a_pause = 1'b0;
        b_start = 1'b0; b_pause = 1'b0;
        c_start = 1'b0; c_pause = 1'b0;
        test_reset();
        test_sweep();
        test_pause();
        test_eq_pause_and_reset();
        test_overshoot();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
